// File: rtl/adxl362_spi_reader_if.sv
// Host-side request/response bundle for the ADXL362 burst reader.
// The master drives a read request; the slave reports progress and received bytes.
interface adxl362_spi_reader_if;
   logic       start;
   logic [7:0] addr;
   logic [3:0] len;
   logic       busy;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       done;

   modport master (
      output start, addr, len,
      input  busy, rd_data, rd_valid, done
   );

   modport slave (
      input  start, addr, len,
      output busy, rd_data, rd_valid, done
   );
endinterface

// File: rtl/adxl362_spi_reader.sv
// SPI mode-0 master issuing an ADXL362 READ (0x0B) burst: command, start address,
// then 1..15 data bytes clocked in MSB first and presented one strobe per byte.
module adxl362_spi_reader #(
   parameter int CLK_DIV = 5
) (
   input  logic                        clk,
   input  logic                        reset_n,
   adxl362_spi_reader_if.slave         host,
   output logic                        spi_cs_n,
   output logic                        spi_sclk,
   output logic                        spi_mosi,
   input  logic                        spi_miso
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [7:0] READ_CMD = 8'h0B;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t           state_q,     state_d;
   logic [DIV_W-1:0] div_q,       div_d;
   logic             sclk_q,      sclk_d;
   logic             cs_n_q,      cs_n_d;
   logic             busy_q,      busy_d;
   logic [2:0]       bit_q,       bit_d;
   logic [4:0]       byte_q,      byte_d;
   logic [4:0]       last_byte_q, last_byte_d;
   logic [7:0]       addr_q,      addr_d;
   logic [7:0]       tx_q,        tx_d;
   logic [6:0]       rx_q,        rx_d;
   logic [7:0]       rd_data_q,   rd_data_d;
   logic             rd_valid_q,  rd_valid_d;
   logic             done_q,      done_d;
   logic             div_end;

   assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

   // Every SPI pin and host output comes straight from a flop so reset takes effect immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         div_q       <= '0;
         sclk_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         bit_q       <= '0;
         byte_q      <= '0;
         last_byte_q <= '0;
         addr_q      <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         last_byte_q <= last_byte_d;
         addr_q      <= addr_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_d       = div_end ? '0 : div_q + DIV_W'(1);
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      busy_d      = busy_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      last_byte_d = last_byte_q;
      addr_d      = addr_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            div_d = '0;
            // The done cycle already reads busy=0, but a start there must still be dropped.
            if (host.start && !done_q) begin
               state_d     = SETUP;
               cs_n_d      = 1'b0;
               busy_d      = 1'b1;
               sclk_d      = 1'b0;
               bit_d       = '0;
               byte_d      = '0;
               addr_d      = host.addr;
               last_byte_d = (host.len == 4'd0) ? 5'd2 : {1'b0, host.len} + 5'd1;
               tx_d        = READ_CMD;
            end
         end

         SETUP: begin
            if (div_end) begin
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (div_end) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[5:0], spi_miso};
                  if (bit_q == 3'd7 && byte_q >= 5'd2) begin
                     rd_data_d  = {rx_q, spi_miso};
                     rd_valid_d = 1'b1;
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     bit_d = '0;
                     if (byte_q == last_byte_q) begin
                        state_d = HOLD;
                        tx_d    = '0;
                     end else begin
                        byte_d = byte_q + 5'd1;
                        tx_d   = (byte_q == 5'd0) ? addr_q : 8'h00;
                     end
                  end else begin
                     bit_d = bit_q + 3'd1;
                     tx_d  = {tx_q[6:0], 1'b0};
                  end
               end
            end
         end

         HOLD: begin
            if (div_end) begin
               state_d = GAP;
               cs_n_d  = 1'b1;
            end
         end

         GAP: begin
            if (div_end) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            busy_d  = 1'b0;
            tx_d    = '0;
         end
      endcase
   end

   assign spi_cs_n      = cs_n_q;
   assign spi_sclk      = sclk_q;
   assign spi_mosi      = tx_q[7];
   assign host.busy     = busy_q;
   assign host.rd_data  = rd_data_q;
   assign host.rd_valid = rd_valid_q;
   assign host.done     = done_q;

endmodule

// File: tb/tb_adxl362_spi_reader.sv
// Directed bench for adxl362_spi_reader: a behavioural ADXL362 answers on MISO while
// monitors collect MOSI bytes, strobes and SPI phase timing for each scenario task.
module tb_adxl362_spi_reader;

   localparam int CLK_DIV = 5;

   logic clk;
   logic reset_n;
   logic spi_cs_n;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_miso;

   adxl362_spi_reader_if bus ();

   adxl362_spi_reader #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .host     (bus),
      .spi_cs_n (spi_cs_n),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_compared;
   int n_mismatched;

   logic [7:0] slave_data [0:16];
   int         sl_bit;
   int         sl_byte;

   logic [7:0] mosi_bytes [$];
   logic [7:0] rv_vals [$];
   logic [7:0] mon_sh;
   int         mon_bits;
   int         rise_cnt;
   int         done_cnt, done_bad, busy_cycles, cs_low_cycles, cs_rise_cnt;
   int         gap_cnt, gap_len, cs_cnt, cs_to_rise, high_run, low_run;
   int         mosi_err, high_err, low_err;
   logic       prev_sclk, prev_cs, prev_busy, prev_mosi, seen_rise, seen_fall;

   function automatic logic [7:0] slave_byte(input int k);
      if (k < 2) return 8'hFF;
      return slave_data[k - 2];
   endfunction

   // Behavioural ADXL362: first bit valid at CS fall, later bits shifted out on SCLK falls.
   always @(negedge spi_cs_n) begin
      logic [7:0] b;
      sl_bit  = 0;
      sl_byte = 0;
      b = slave_byte(0);
      spi_miso = b[7];
   end

   always @(negedge spi_sclk) begin
      logic [7:0] b;
      if (!spi_cs_n) begin
         sl_bit++;
         if (sl_bit == 8) begin
            sl_bit = 0;
            sl_byte++;
         end
         b = slave_byte(sl_byte);
         spi_miso = b[7 - sl_bit];
      end
   end

   always @(posedge spi_sclk) begin
      if (!spi_cs_n) begin
         rise_cnt++;
         mon_sh = {mon_sh[6:0], spi_mosi};
         mon_bits++;
         if (mon_bits == 8) begin
            mosi_bytes.push_back(mon_sh);
            mon_bits = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_sclk = 1'b0;
         prev_cs   = 1'b1;
         prev_busy = 1'b0;
         prev_mosi = 1'b0;
         seen_rise = 1'b0;
         seen_fall = 1'b0;
      end else begin
         if (prev_cs && !spi_cs_n) begin
            cs_cnt = 0; seen_rise = 1'b0; seen_fall = 1'b0; high_run = 0; low_run = 0;
         end
         if (!prev_cs && spi_cs_n) cs_rise_cnt++;
         if (!spi_cs_n) cs_low_cycles++;
         if (bus.busy) busy_cycles++;
         if (bus.busy && spi_cs_n) gap_cnt++;
         if (prev_sclk && spi_sclk && spi_mosi !== prev_mosi) mosi_err++;
         if (!spi_cs_n && !spi_sclk && !seen_rise) cs_cnt++;
         if (spi_sclk) begin
            if (!prev_sclk) begin
               if (seen_fall && low_run != CLK_DIV) low_err++;
               if (!seen_rise) cs_to_rise = cs_cnt;
               seen_rise = 1'b1;
               high_run  = 0;
            end
            high_run++;
         end else begin
            if (prev_sclk) begin
               if (high_run != CLK_DIV) high_err++;
               seen_fall = 1'b1;
               low_run   = 0;
            end
            if (!spi_cs_n) low_run++;
         end
         if (bus.rd_valid) rv_vals.push_back(bus.rd_data);
         if (bus.done) begin
            done_cnt++;
            if (bus.busy !== 1'b0 || prev_busy !== 1'b1) done_bad++;
            gap_len = gap_cnt;
            gap_cnt = 0;
         end
         prev_sclk = spi_sclk;
         prev_cs   = spi_cs_n;
         prev_busy = bus.busy;
         prev_mosi = spi_mosi;
      end
   end

   task automatic clear_monitors();
      mosi_bytes.delete();
      rv_vals.delete();
      mon_bits = 0; mon_sh = 8'h00; rise_cnt = 0;
      done_cnt = 0; done_bad = 0; busy_cycles = 0; cs_low_cycles = 0; cs_rise_cnt = 0;
      gap_cnt = 0; gap_len = -1; cs_to_rise = -1;
   endtask

   task automatic do_start(input logic [7:0] a, input logic [3:0] l);
      @(negedge clk);
      bus.start = 1'b1;
      bus.addr  = a;
      bus.len   = l;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (done_cnt == 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt == 0) begin
         n_compared++; n_mismatched++;
         $display("[TB] FAIL %s_timeout: no done within %0d cycles", name, t);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.addr = 8'h00; bus.len = 4'd0;
      repeat (3) @(negedge clk);
      n_compared++;
      if ({spi_cs_n, spi_sclk, spi_mosi, bus.busy, bus.rd_valid, bus.done} !== 6'b100000) begin
         n_mismatched++;
         $display("[TB] FAIL reset_pins: got cs/sclk/mosi/busy/rv/done=%b want 100000",
                  {spi_cs_n, spi_sclk, spi_mosi, bus.busy, bus.rd_valid, bus.done});
      end
      n_compared++;
      if (bus.rd_data !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL reset_rd_data: got %h want 00", bus.rd_data);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_read();
      clear_monitors();
      slave_data[0] = 8'hAD;
      do_start(8'h00, 4'd1);
      wait_done("single");
      n_compared++;
      if (mosi_bytes.size() != 3 || {mosi_bytes[0], mosi_bytes[1], mosi_bytes[2]} !== 24'h0B0000) begin
         n_mismatched++;
         $display("[TB] FAIL single_mosi: got %0d bytes %h%h%h want 0B0000", mosi_bytes.size(),
                  mosi_bytes[0], mosi_bytes[1], mosi_bytes[2]);
      end
      n_compared++;
      if (rise_cnt != 24) begin
         n_mismatched++;
         $display("[TB] FAIL single_rises: got %0d want 24", rise_cnt);
      end
      n_compared++;
      if (rv_vals.size() != 1 || rv_vals[0] !== 8'hAD) begin
         n_mismatched++;
         $display("[TB] FAIL single_rd: got %0d strobes first %h want 1 strobe AD", rv_vals.size(), rv_vals[0]);
      end
      n_compared++;
      if (busy_cycles != 255) begin
         n_mismatched++;
         $display("[TB] FAIL single_busy_len: got %0d want 255", busy_cycles);
      end
      n_compared++;
      if (done_cnt != 1 || done_bad != 0) begin
         n_mismatched++;
         $display("[TB] FAIL single_done: got %0d pulses %0d misaligned want 1 aligned", done_cnt, done_bad);
      end
      n_compared++;
      if (bus.rd_data !== 8'hAD) begin
         n_mismatched++;
         $display("[TB] FAIL single_rd_hold: got %h want AD", bus.rd_data);
      end
   endtask

   task automatic test_burst();
      clear_monitors();
      slave_data[0] = 8'h12; slave_data[1] = 8'h34; slave_data[2] = 8'h56;
      do_start(8'h0E, 4'd3);
      wait_done("burst");
      n_compared++;
      if (rv_vals.size() != 3 || {rv_vals[0], rv_vals[1], rv_vals[2]} !== 24'h123456) begin
         n_mismatched++;
         $display("[TB] FAIL burst_rd: got %0d strobes %h%h%h want 123456", rv_vals.size(),
                  rv_vals[0], rv_vals[1], rv_vals[2]);
      end
      n_compared++;
      if (rise_cnt != 40) begin
         n_mismatched++;
         $display("[TB] FAIL burst_rises: got %0d want 40", rise_cnt);
      end
      n_compared++;
      if (mosi_bytes.size() != 5 ||
          {mosi_bytes[0], mosi_bytes[1], mosi_bytes[2], mosi_bytes[3], mosi_bytes[4]} !== 40'h0B0E000000) begin
         n_mismatched++;
         $display("[TB] FAIL burst_mosi: got %0d bytes, addr byte %h want 5 bytes 0B0E000000",
                  mosi_bytes.size(), mosi_bytes[1]);
      end
      n_compared++;
      if (cs_rise_cnt != 1 || cs_low_cycles != 410) begin
         n_mismatched++;
         $display("[TB] FAIL burst_cs: got %0d releases %0d low cycles want 1 and 410", cs_rise_cnt, cs_low_cycles);
      end
      n_compared++;
      if (busy_cycles != 415) begin
         n_mismatched++;
         $display("[TB] FAIL burst_busy_len: got %0d want 415", busy_cycles);
      end
   endtask

   task automatic test_timing();
      n_compared++;
      if (mosi_err != 0) begin
         n_mismatched++;
         $display("[TB] FAIL timing_mosi_stable: got %0d changes while SCLK high want 0", mosi_err);
      end
      n_compared++;
      if (high_err != 0 || low_err != 0) begin
         n_mismatched++;
         $display("[TB] FAIL timing_phases: got %0d bad high %0d bad low want 0 0", high_err, low_err);
      end
      n_compared++;
      if (cs_to_rise != 2 * CLK_DIV) begin
         n_mismatched++;
         $display("[TB] FAIL timing_cs_to_rise: got %0d want %0d", cs_to_rise, 2 * CLK_DIV);
      end
      n_compared++;
      if (gap_len != CLK_DIV) begin
         n_mismatched++;
         $display("[TB] FAIL timing_cs_gap: got %0d want %0d", gap_len, CLK_DIV);
      end
   endtask

   task automatic test_ignore_start();
      clear_monitors();
      slave_data[0] = 8'h3C;
      do_start(8'h21, 4'd1);
      repeat (18) @(negedge clk);
      bus.start = 1'b1; bus.addr = 8'h55; bus.len = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ignore");
      n_compared++;
      if (mosi_bytes.size() != 3 || mosi_bytes[1] !== 8'h21) begin
         n_mismatched++;
         $display("[TB] FAIL ignore_addr: got %0d bytes addr %h want 3 bytes addr 21", mosi_bytes.size(), mosi_bytes[1]);
      end
      n_compared++;
      if (done_cnt != 1 || rv_vals.size() != 1) begin
         n_mismatched++;
         $display("[TB] FAIL ignore_done: got %0d done %0d strobes want 1 1", done_cnt, rv_vals.size());
      end
   endtask

   task automatic test_start_on_done();
      int t;
      clear_monitors();
      slave_data[0] = 8'h77;
      do_start(8'h02, 4'd1);
      t = 0;
      while (bus.done !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      bus.start = 1'b1; bus.addr = 8'h03; bus.len = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      n_compared++;
      if (bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL done_cycle_start: got busy=%b want 0", bus.busy);
      end
      do_start(8'h03, 4'd1);
      n_compared++;
      if (bus.busy !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL after_done_start: got busy=%b want 1", bus.busy);
      end
      repeat (300) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      clear_monitors();
      slave_data[0] = 8'h99; slave_data[1] = 8'h88;
      do_start(8'h10, 4'd2);
      repeat (99) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_compared++;
      if ({spi_cs_n, spi_sclk, bus.busy} !== 3'b100) begin
         n_mismatched++;
         $display("[TB] FAIL abort_pins: got cs/sclk/busy=%b want 100", {spi_cs_n, spi_sclk, bus.busy});
      end
      repeat (3) @(negedge clk);
      n_compared++;
      if (done_cnt != 0 || rv_vals.size() != 0 || bus.rd_data !== 8'h00) begin
         n_mismatched++;
         $display("[TB] FAIL abort_quiet: got %0d done %0d strobes rd_data %h want 0 0 00",
                  done_cnt, rv_vals.size(), bus.rd_data);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      clear_monitors();
      slave_data[0] = 8'h5A;
      do_start(8'h0F, 4'd1);
      wait_done("recover");
      n_compared++;
      if (rv_vals.size() != 1 || rv_vals[0] !== 8'h5A || done_cnt != 1) begin
         n_mismatched++;
         $display("[TB] FAIL recover_read: got %0d strobes %h, %0d done want 1 5A 1", rv_vals.size(), rv_vals[0], done_cnt);
      end
   endtask

   task automatic test_len_zero();
      clear_monitors();
      slave_data[0] = 8'hC3;
      do_start(8'h08, 4'd0);
      wait_done("len0");
      n_compared++;
      if (rise_cnt != 24 || rv_vals.size() != 1 || rv_vals[0] !== 8'hC3) begin
         n_mismatched++;
         $display("[TB] FAIL len0_read: got %0d rises %0d strobes %h want 24 1 C3", rise_cnt, rv_vals.size(), rv_vals[0]);
      end
      n_compared++;
      if (mosi_bytes.size() != 3 || {mosi_bytes[0], mosi_bytes[1], mosi_bytes[2]} !== 24'h0B0800 || busy_cycles != 255) begin
         n_mismatched++;
         $display("[TB] FAIL len0_frame: got %0d bytes addr %h busy %0d want 0B0800 busy 255",
                  mosi_bytes.size(), mosi_bytes[1], busy_cycles);
      end
   endtask

   initial begin
      n_compared = 0; n_mismatched = 0;
      mosi_err = 0; high_err = 0; low_err = 0;
      high_run = 0; low_run = 0; cs_cnt = 0;
      spi_miso = 1'b0;
      for (int i = 0; i < 17; i++) slave_data[i] = 8'h00;
      clear_monitors();
      test_reset();
      test_single_read();
      test_burst();
      test_timing();
      test_ignore_start();
      test_start_on_done();
      test_reset_abort();
      test_len_zero();
      test_timing();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
